// File: rtl/cpu_pkg.sv
// Shared datapath definitions: default widths and the per-lane holding state.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_OUT_DEF  = 4;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output lane, with load, drain and flush.
module demux_slot
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  lane_state_t       state_q;
  lane_state_t       state_n;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LANE_EMPTY;
    end else begin
      state_q <= state_n;
    end
  end

  // A drain and a load in the same cycle keep the lane FULL with the new word.
  always_comb begin
    state_n = state_q;
    case (state_q)
      LANE_EMPTY: if (!flush && load) state_n = LANE_FULL;
      LANE_FULL: begin
        if (flush)              state_n = LANE_EMPTY;
        else if (!load && ready) state_n = LANE_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load && !flush) begin
      data_q <= load_data;
    end
  end

  assign valid = (state_q == LANE_FULL);
  assign data  = data_q;

endmodule

// File: rtl/bus_demux.sv
// One-to-N stream router: steers each accepted word into the holding slot picked by in_sel.
module bus_demux
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_OUT  = N_OUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(N_OUT)-1:0]   in_sel,
  input  logic [DATA_W-1:0]          in_data,
  output logic [N_OUT-1:0]           out_valid,
  input  logic [N_OUT-1:0]           out_ready,
  output logic [N_OUT*DATA_W-1:0]    out_data,
  output logic [15:0]                xfer_cnt
);

  localparam int SEL_W = $clog2(N_OUT);

  logic             accept;
  logic [N_OUT-1:0] load;
  logic [15:0]      cnt_q;

  // The selected lane can take a word if it is empty or is being drained this cycle.
  assign in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    assign load[i] = accept && (in_sel == SEL_W'(i));

    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (load[i]),
      .ready    (out_ready[i]),
      .load_data(in_data),
      .valid    (out_valid[i]),
      .data     (out_data[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;

endmodule
